// File: rtl/cluster_periph_plug_arbiter.sv
// Merges NB_PLUGS peripheral-interconnect slave plugs onto one target port.
// A selection made in IDLE is forwarded in the same cycle. If the target does
// not grant, it is locked and held. Granted winners are queued in a response
// FIFO so that each target response can be steered back to its plug.
// Optional feature: define CLUSTER_PERIPH_ARB_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest index wins.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   plug_req/add/wen/wdata/be/id_i  per-plug request
//   plug_gnt_o, plug_r_valid_o      per-plug grant / response valid
//   plug_r_rdata/opc/id_o           shared response fields (pass-through)
//   tgt_req/add/wen/wdata/be/id_o   merged request, tgt_gnt_i its grant
//   tgt_r_valid/rdata/opc/id_i      target response
//   resp_err_o                      pulse: response with nothing outstanding
module cluster_periph_plug_arbiter #(
   parameter int unsigned NB_PLUGS   = 2,
   parameter int unsigned ID_WIDTH   = 5,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NB_PLUGS-1:0]                plug_req_i,
   input  logic [NB_PLUGS-1:0][31:0]          plug_add_i,
   input  logic [NB_PLUGS-1:0]                plug_wen_i,
   input  logic [NB_PLUGS-1:0][31:0]          plug_wdata_i,
   input  logic [NB_PLUGS-1:0][3:0]           plug_be_i,
   input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  plug_id_i,
   output logic [NB_PLUGS-1:0]                plug_gnt_o,
   output logic [NB_PLUGS-1:0]                plug_r_valid_o,
   output logic [31:0]                        plug_r_rdata_o,
   output logic                               plug_r_opc_o,
   output logic [ID_WIDTH-1:0]                plug_r_id_o,
   output logic                               tgt_req_o,
   output logic [31:0]                        tgt_add_o,
   output logic                               tgt_wen_o,
   output logic [31:0]                        tgt_wdata_o,
   output logic [3:0]                         tgt_be_o,
   output logic [ID_WIDTH-1:0]                tgt_id_o,
   input  logic                               tgt_gnt_i,
   input  logic                               tgt_r_valid_i,
   input  logic [31:0]                        tgt_r_rdata_i,
   input  logic                               tgt_r_opc_i,
   input  logic [ID_WIDTH-1:0]                tgt_r_id_i,
   output logic                               resp_err_o
);

   localparam int unsigned IDX_W = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
   localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       sel_q, sel_c, win;
   logic [31:0]            add_q, wdata_q;
   logic                   wen_q;
   logic [3:0]             be_q;
   logic [ID_WIDTH-1:0]    id_q;
   logic [IDX_W-1:0]       fifo_q [RESP_DEPTH];
   logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   any_req, locked, grant, pop;
   logic [IDX_W-1:0]       head;
`ifdef CLUSTER_PERIPH_ARB_RR_EN
   logic [IDX_W-1:0]       rr_q, rr_d;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Winner search over the current requests
   always_comb begin
      win     = '0;
      any_req = 1'b0;
`ifdef CLUSTER_PERIPH_ARB_RR_EN
      for (int unsigned i = 0; i < NB_PLUGS; i++) begin
         logic [IDX_W-1:0] idx;
         idx = IDX_W'((32'(rr_q) + i) % NB_PLUGS);
         if (!any_req && plug_req_i[idx]) begin
            any_req = 1'b1;
            win     = idx;
         end
      end
`else
      for (int unsigned i = NB_PLUGS; i > 0; i--) begin
         if (plug_req_i[IDX_W'(i - 1)]) win = IDX_W'(i - 1);
      end
      any_req = |plug_req_i;
`endif
   end

   assign locked = (state_q == LOCKED);
   assign sel_c  = locked ? sel_q : win;

   // Only a locked selection or a fresh one with FIFO room reaches the target
   assign tgt_req_o   = !rst_i && (locked || (any_req && (cnt_q < CNT_W'(RESP_DEPTH))));
   assign tgt_add_o   = locked ? add_q   : plug_add_i[win];
   assign tgt_wen_o   = locked ? wen_q   : plug_wen_i[win];
   assign tgt_wdata_o = locked ? wdata_q : plug_wdata_i[win];
   assign tgt_be_o    = locked ? be_q    : plug_be_i[win];
   assign tgt_id_o    = locked ? id_q    : plug_id_i[win];

   assign grant = tgt_req_o && tgt_gnt_i;
   assign pop   = !rst_i && tgt_r_valid_i && (cnt_q != '0);
   assign head  = fifo_q[rptr_q];

   assign plug_r_rdata_o = tgt_r_rdata_i;
   assign plug_r_opc_o   = tgt_r_opc_i;
   assign plug_r_id_o    = tgt_r_id_i;
   assign resp_err_o     = err_q;

   // One-hot steering of grant and response valid
   always_comb begin
      plug_gnt_o     = '0;
      plug_r_valid_o = '0;
      if (grant) plug_gnt_o[sel_c]  = 1'b1;
      if (pop)   plug_r_valid_o[head] = 1'b1;
   end

   // Next-state logic
   always_comb begin
      state_d = (tgt_req_o && !tgt_gnt_i) ? LOCKED : IDLE;
      wptr_d  = grant ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = pop   ? ptr_inc(rptr_q) : rptr_q;
      cnt_d   = cnt_q;
      if (grant && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!grant && pop) cnt_d = cnt_q - CNT_W'(1);
      err_d   = tgt_r_valid_i && (cnt_q == '0);
`ifdef CLUSTER_PERIPH_ARB_RR_EN
      rr_d = rr_q;
      if (grant) rr_d = (sel_c == IDX_W'(NB_PLUGS - 1)) ? '0 : sel_c + IDX_W'(1);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         add_q   <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         id_q    <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         for (int unsigned i = 0; i < RESP_DEPTH; i++) fifo_q[i] <= '0;
`ifdef CLUSTER_PERIPH_ARB_RR_EN
         rr_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         // Capture what is being presented so a lock holds it unchanged
         sel_q   <= sel_c;
         add_q   <= tgt_add_o;
         wen_q   <= tgt_wen_o;
         wdata_q <= tgt_wdata_o;
         be_q    <= tgt_be_o;
         id_q    <= tgt_id_o;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (grant) fifo_q[wptr_q] <= sel_c;
`ifdef CLUSTER_PERIPH_ARB_RR_EN
         rr_q    <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_cluster_periph_plug_arbiter.sv
module tb_cluster_periph_plug_arbiter;

`ifdef CLUSTER_PERIPH_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       plug_req, plug_wen, plug_gnt, plug_r_valid;
   logic [1:0][31:0] plug_add, plug_wdata;
   logic [1:0][3:0]  plug_be;
   logic [1:0][4:0]  plug_id;
   logic [31:0]      r_rdata, tgt_add, tgt_wdata, tgt_r_rdata;
   logic             r_opc, tgt_req, tgt_wen, tgt_gnt, tgt_r_valid, tgt_r_opc, resp_err;
   logic [4:0]       r_id, tgt_id, tgt_r_id;
   logic [3:0]       tgt_be;

   int errors = 0;
   int checks = 0;

   cluster_periph_plug_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .plug_req_i(plug_req), .plug_add_i(plug_add), .plug_wen_i(plug_wen),
      .plug_wdata_i(plug_wdata), .plug_be_i(plug_be), .plug_id_i(plug_id),
      .plug_gnt_o(plug_gnt), .plug_r_valid_o(plug_r_valid),
      .plug_r_rdata_o(r_rdata), .plug_r_opc_o(r_opc), .plug_r_id_o(r_id),
      .tgt_req_o(tgt_req), .tgt_add_o(tgt_add), .tgt_wen_o(tgt_wen),
      .tgt_wdata_o(tgt_wdata), .tgt_be_o(tgt_be), .tgt_id_o(tgt_id),
      .tgt_gnt_i(tgt_gnt), .tgt_r_valid_i(tgt_r_valid), .tgt_r_rdata_i(tgt_r_rdata),
      .tgt_r_opc_i(tgt_r_opc), .tgt_r_id_i(tgt_r_id), .resp_err_o(resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change 1 time unit after the rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] e_a, e_b;

   initial begin
      rst = 1'b1; plug_req = '0; plug_wen = '0; plug_add = '0; plug_wdata = '0;
      plug_be = '0; plug_id = '0; tgt_gnt = 1'b0; tgt_r_valid = 1'b0;
      tgt_r_rdata = '0; tgt_r_opc = 1'b0; tgt_r_id = '0;
      cyc(); cyc();
      // Outputs gated while in reset
      plug_req = 2'b11; tgt_gnt = 1'b1; tgt_r_valid = 1'b1; #2;
      check("rst_tgt_req", 64'(tgt_req), 0);
      check("rst_gnt", 64'(plug_gnt), 0);
      check("rst_rvalid", 64'(plug_r_valid), 0);
      cyc();
      check("rst_err", 64'(resp_err), 0);
      plug_req = '0; tgt_gnt = 1'b0; tgt_r_valid = 1'b0; rst = 1'b0;
      cyc();

      // Single read from plug 1
      plug_req = 2'b10; plug_add[1] = 32'h0000_0400; plug_wen[1] = 1'b1; plug_id[1] = 5'd3;
      plug_be[1] = 4'hF; tgt_gnt = 1'b1; #2;
      check("single_req", 64'(tgt_req), 1);
      check("single_add", 64'(tgt_add), 64'h400);
      check("single_id", 64'(tgt_id), 3);
      check("single_wen", 64'(tgt_wen), 1);
      check("single_gnt", 64'(plug_gnt), 2'b10);
      cyc();
      plug_req = '0; tgt_r_valid = 1'b1; tgt_r_rdata = 32'hCAFE_0001; tgt_r_id = 5'd3; #2;
      check("single_rvalid", 64'(plug_r_valid), 2'b10);
      check("single_rdata", 64'(r_rdata), 64'hCAFE_0001);
      check("single_rid", 64'(r_id), 3);
      check("single_idle", 64'(tgt_req), 0);
      cyc();
      tgt_r_valid = 1'b0; #2;
      check("single_noerr", 64'(resp_err), 0);

      // Contention: both plugs request for 4 cycles, target always grants
      plug_req = 2'b11; plug_add[0] = 32'h100; plug_id[0] = 5'd7;
      for (int c = 0; c < 4; c++) begin
         e_a = (RR && (c % 2 == 1)) ? 2'b10 : 2'b01;
         e_b = (RR && (c % 2 == 0)) ? 2'b10 : 2'b01;
         tgt_r_valid = (c != 0); #2;
         check($sformatf("cont_gnt%0d", c), 64'(plug_gnt), 64'(e_a));
         if (c != 0) check($sformatf("cont_rv%0d", c), 64'(plug_r_valid), 64'(e_b));
         cyc();
      end
      plug_req = '0; tgt_r_valid = 1'b1; #2;
      check("cont_drain", 64'(plug_r_valid), RR ? 2'b10 : 2'b01);
      cyc();

      // Lock: plug 0 selected, target stalls 3 cycles, plug 0 drops req
      tgt_r_valid = 1'b0; tgt_gnt = 1'b0; plug_req = 2'b01; #2;
      check("lock_add0", 64'(tgt_add), 64'h100);
      check("lock_gnt0", 64'(plug_gnt), 0);
      cyc();
      plug_req = 2'b10; plug_add[0] = 32'hDEAD; plug_id[0] = 5'd1;
      plug_add[1] = 32'h200; plug_id[1] = 5'd2; #2;
      check("lock_req1", 64'(tgt_req), 1);
      check("lock_add1", 64'(tgt_add), 64'h100);
      check("lock_id1", 64'(tgt_id), 7);
      cyc(); #2;
      check("lock_add2", 64'(tgt_add), 64'h100);
      check("lock_id2", 64'(tgt_id), 7);
      cyc();
      tgt_gnt = 1'b1; #2;
      check("lock_gnt3", 64'(plug_gnt), 2'b01);
      check("lock_add3", 64'(tgt_add), 64'h100);
      cyc();
      plug_req = '0; tgt_r_valid = 1'b1; #2;
      check("lock_rv", 64'(plug_r_valid), 2'b01);
      cyc();

      // Full: two grants without responses block further requests
      tgt_r_valid = 1'b0; plug_req = 2'b11; #2;
      check("full_g0", 64'(plug_gnt), RR ? 2'b10 : 2'b01);
      cyc(); #2;
      check("full_g1", 64'(plug_gnt), 2'b01);
      cyc(); #2;
      check("full_req2", 64'(tgt_req), 0);
      check("full_gnt2", 64'(plug_gnt), 0);
      cyc();
      tgt_r_valid = 1'b1; #2;
      check("full_req3", 64'(tgt_req), 0);
      check("full_rv3", 64'(plug_r_valid), RR ? 2'b10 : 2'b01);
      cyc();
      tgt_r_valid = 1'b0; #2;
      check("full_req4", 64'(tgt_req), 1);
      check("full_g4", 64'(plug_gnt), RR ? 2'b10 : 2'b01);
      cyc();
      plug_req = '0; tgt_r_valid = 1'b1; #2;
      check("full_rv5", 64'(plug_r_valid), 2'b01);
      cyc(); #2;
      check("full_rv6", 64'(plug_r_valid), RR ? 2'b10 : 2'b01);
      cyc();

      // Response with an empty FIFO
      #2;
      check("err_rv", 64'(plug_r_valid), 0);
      cyc();
      tgt_r_valid = 1'b0; #2;
      check("err_pulse", 64'(resp_err), 1);
      cyc(); #2;
      check("err_clear", 64'(resp_err), 0);

      // Reset with one transaction outstanding
      plug_req = 2'b01; #2;
      check("rst_out_gnt", 64'(plug_gnt), 2'b01);
      cyc();
      rst = 1'b1; #2;
      check("rst_in_req", 64'(tgt_req), 0);
      check("rst_in_gnt", 64'(plug_gnt), 0);
      cyc();
      rst = 1'b0; plug_req = '0; tgt_r_valid = 1'b1; #2;
      check("rst_after_req", 64'(tgt_req), 0);
      check("rst_after_rv", 64'(plug_r_valid), 0);
      cyc();
      tgt_r_valid = 1'b0; #2;
      check("rst_after_err", 64'(resp_err), 1);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
